// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multi-cycle RV32I control path:
//   - fmt_t   : instruction class codes handed to the ALU decoder (0..9)
//   - OP_*    : RV32I major opcodes recognised by the control unit
//   - state_t : control FSM state encoding
//   - *_SRC / RES_* / ADR_* : datapath mux-select encodings
//   - branch_taken / branch_f3_legal : branch condition helpers
// -----------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic [3:0] {
      FMT_R  = 4'd0,
      FMT_I  = 4'd1,
      FMT_IL = 4'd2,
      FMT_IE = 4'd3,
      FMT_S  = 4'd4,
      FMT_B  = 4'd5,
      FMT_J  = 4'd6,
      FMT_JI = 4'd7,
      FMT_U  = 4'd8,
      FMT_UP = 4'd9
   } fmt_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_IL = 7'b0000011;
   localparam logic [6:0] OP_IE = 7'b1110011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JI = 7'b1100111;
   localparam logic [6:0] OP_U  = 7'b0110111;
   localparam logic [6:0] OP_UP = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   localparam logic [1:0] ALU_A_RS1    = 2'd0;
   localparam logic [1:0] ALU_A_OLD_PC = 2'd1;
   localparam logic [1:0] ALU_A_ZERO   = 2'd2;

   // Code 2'd2 on alu_src_b is the constant 4; the fetch increment goes
   // through pc_src instead, so the control unit never selects it.
   localparam logic [1:0] ALU_B_RS2 = 2'd0;
   localparam logic [1:0] ALU_B_IMM = 2'd1;

   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_PC  = 2'd2;

   localparam logic PC_SRC_PLUS4 = 1'b0;
   localparam logic PC_SRC_ALU   = 1'b1;

   localparam logic ADR_PC  = 1'b0;
   localparam logic ADR_ALU = 1'b1;

   // Branch condition from the comparator flags; funct3 2/3 never reach
   // EXEC because they trap in DECODE.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       eq,
                                         input logic       lt,
                                         input logic       ltu);
      logic taken;
      case (funct3)
         3'd0:    taken = eq;
         3'd1:    taken = !eq;
         3'd4:    taken = lt;
         3'd5:    taken = !lt;
         3'd6:    taken = ltu;
         3'd7:    taken = !ltu;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   function automatic logic branch_f3_legal(input logic [2:0] funct3);
      return (funct3 != 3'd2) && (funct3 != 3'd3);
   endfunction

endpackage

// File: rtl/fmt_dec.sv
// -----------------------------------------------------------------------------
// fmt_dec
// Combinational opcode -> instruction class mapping.
// Ports:
//   opcode : instr[6:0]
//   funct3 : instr[14:12], only consulted to reject reserved branch codes
//   fmt    : class code (FMT_R when the opcode is unknown)
//   legal  : 1 when the opcode/funct3 combination is supported
// -----------------------------------------------------------------------------
module fmt_dec
   import riscv_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output fmt_t       fmt,
   output logic       legal
);

   always_comb begin
      // NOTE: every output gets a default before the case, so no path
      // leaves a value unassigned and no latch is inferred.
      fmt   = FMT_R;
      legal = 1'b1;
      case (opcode)
         OP_R:  fmt = FMT_R;
         OP_I:  fmt = FMT_I;
         OP_IL: fmt = FMT_IL;
         OP_IE: fmt = FMT_IE;
         OP_S:  fmt = FMT_S;
         OP_B: begin
            fmt   = FMT_B;
            legal = branch_f3_legal(funct3);
         end
         OP_J:  fmt = FMT_J;
         OP_JI: fmt = FMT_JI;
         OP_U:  fmt = FMT_U;
         OP_UP: fmt = FMT_UP;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/ctrl_fsm.sv
// -----------------------------------------------------------------------------
// ctrl_fsm
// Multi-cycle RV32I main control unit. Sequences FETCH/DECODE/EXEC/MEM/WB for
// one instruction at a time over a shared memory req/ready handshake, holds
// the class code for the ALU decoder and drives the datapath selects/enables.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   instr                 : instruction register (valid from DECODE onward)
//   mem_ready             : memory completes the current access this cycle
//   br_eq/br_lt/br_ltu    : comparator flags for branches
//   fmt, funct3, funct7   : to the ALU decoder
//   mem_req, mem_we       : memory request / write strobe
//   adr_src               : memory address select (PC / ALU result register)
//   ir_write, pc_write    : IR + old_pc load, PC update
//   pc_src                : PC+4 / ALU result
//   alu_src_a, alu_src_b  : ALU operand selects
//   result_src, reg_write : register file write-back select / enable
//   halt, illegal         : sticky ECALL/EBREAK and unsupported-instruction flags
//   instret               : retired-instruction count, wraps
// -----------------------------------------------------------------------------
module ctrl_fsm
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             mem_ready,
   input  logic             br_eq,
   input  logic             br_lt,
   input  logic             br_ltu,
   output logic [3:0]       fmt,
   output logic [2:0]       funct3,
   output logic [6:0]       funct7,
   output logic             mem_req,
   output logic             mem_we,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic             reg_write,
   output logic             halt,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_t            state_q;
   state_t            state_d;
   fmt_t              fmt_q;
   fmt_t              dec_fmt;
   logic              dec_legal;
   logic              retire;
   logic [CNT_W-1:0]  instret_q;

   fmt_dec u_fmt_dec (
      .opcode (instr[6:0]),
      .funct3 (instr[14:12]),
      .fmt    (dec_fmt),
      .legal  (dec_legal)
   );

   assign fmt     = fmt_q;
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign instret = instret_q;

   // Register/immediate fields are consumed by the datapath, not here.
   logic unused_instr;
   assign unused_instr = ^{instr[24:15], instr[11:7]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   // fmt is captured once per instruction in DECODE and held until the next
   // DECODE; instret counts on the cycle the instruction leaves for FETCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fmt_q     <= FMT_R;
         instret_q <= '0;
      end else begin
         if (state_q == ST_DECODE) fmt_q <= dec_fmt;
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (!dec_legal)             state_d = ST_TRAP;
            else if (dec_fmt == FMT_IE) state_d = ST_HALT;
            else                        state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (fmt_q)
               FMT_B: begin
                  state_d = ST_FETCH;
                  retire  = 1'b1;
               end
               FMT_IL, FMT_S:                         state_d = ST_MEM;
               FMT_R, FMT_I, FMT_U, FMT_UP,
               FMT_J, FMT_JI:                         state_d = ST_WB;
               default:                               state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               if (fmt_q == FMT_S) begin
                  state_d = ST_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_HALT: state_d = ST_HALT;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_FETCH;
      endcase
   end

   // Output decode. Held at zero while rst is high: the reset state is FETCH,
   // which would otherwise raise mem_req during reset itself.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = ADR_PC;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_PLUS4;
      alu_src_a  = ALU_A_RS1;
      alu_src_b  = ALU_B_RS2;
      result_src = RES_ALU;
      reg_write  = 1'b0;
      halt       = 1'b0;
      illegal    = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               mem_req  = 1'b1;
               adr_src  = ADR_PC;
               ir_write = mem_ready;
               pc_write = mem_ready;
               pc_src   = PC_SRC_PLUS4;
            end
            ST_EXEC: begin
               case (fmt_q)
                  FMT_R: begin
                     alu_src_a = ALU_A_RS1;
                     alu_src_b = ALU_B_RS2;
                  end
                  FMT_I, FMT_IL, FMT_S, FMT_JI: begin
                     alu_src_a = ALU_A_RS1;
                     alu_src_b = ALU_B_IMM;
                  end
                  FMT_U: begin
                     alu_src_a = ALU_A_ZERO;
                     alu_src_b = ALU_B_IMM;
                  end
                  FMT_UP, FMT_J, FMT_B: begin
                     alu_src_a = ALU_A_OLD_PC;
                     alu_src_b = ALU_B_IMM;
                  end
                  default: ;
               endcase
               if (fmt_q == FMT_B) begin
                  pc_write = branch_taken(instr[14:12], br_eq, br_lt, br_ltu);
                  pc_src   = PC_SRC_ALU;
               end
               // For JI the datapath clears bit 0 of the target.
               if (fmt_q == FMT_J || fmt_q == FMT_JI) begin
                  pc_write = 1'b1;
                  pc_src   = PC_SRC_ALU;
               end
            end
            ST_MEM: begin
               mem_req = 1'b1;
               adr_src = ADR_ALU;
               mem_we  = (fmt_q == FMT_S);
            end
            ST_WB: begin
               reg_write = 1'b1;
               if (fmt_q == FMT_IL)                        result_src = RES_MEM;
               else if (fmt_q == FMT_J || fmt_q == FMT_JI) result_src = RES_PC;
               else                                        result_src = RES_ALU;
            end
            ST_HALT: halt    = 1'b1;
            ST_TRAP: illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
Multi-cycle RV32I main control unit; sits directly upstream of the ALU decoder.
Sequences FETCH/DECODE/EXECUTE/MEM/WB for one instruction at a time, holds the instruction class code `fmt` stable for the ALU decoder, and drives all datapath mux selects and enables.
Talks to a single shared instruction/data memory through a req/ready handshake.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory completes current access this cycle
br_eq  in  1  rs1==rs2 from comparator
br_lt  in  1  rs1<rs2 signed
br_ltu  in  1  rs1<rs2 unsigned
fmt  out  4  class code to ALU decoder: R=0 I=1 IL=2 IE=3 S=4 B=5 J=6 JI=7 U=8 UP=9
funct3  out  3  instr[14:12] passthrough to ALU decoder
funct7  out  7  instr[31:25] passthrough to ALU decoder
mem_req  out  1  memory access request
mem_we  out  1  write strobe (with mem_req)
adr_src  out  1  0=PC, 1=ALU result register
ir_write  out  1  load IR and capture old_pc
pc_write  out  1  update PC
pc_src  out  1  0=PC+4, 1=ALU result
alu_src_a  out  2  0=rs1, 1=old_pc, 2=zero
alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
result_src  out  2  0=ALU result register, 1=mem data, 2=PC
reg_write  out  1  register file write enable
halt  out  1  ECALL/EBREAK reached; sticky
illegal  out  1  unsupported opcode/funct3; sticky
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset, asynchronous, immediate:
  - state=FETCH, fmt=R (0), instret=0, halt=0, illegal=0.
  - All enables and strobes deasserted.
  - An in-flight mem_req drops at once.
- Outputs are a Moore decode of state plus the registered fmt/instr fields. Exceptions: ir_write, pc_write and branch pc_write, as noted below. Selects not listed for a state are 0.
- FETCH:
  - mem_req=1, adr_src=0.
  - Hold while mem_ready=0.
  - On mem_ready=1 (may arrive in the request cycle): ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE (1 cycle):
  - Register fmt from instr[6:0]:
    - 0110011→R, 0010011→I, 0000011→IL, 1110011→IE, 0100011→S
    - 1100011→B, 1101111→J, 1100111→JI, 0110111→U, 0010111→UP
  - Illegal opcodes, and B with funct3 2 or 3 → TRAP.
  - IE → HALT.
  - All others → EXEC.
- EXEC (1 cycle), per fmt:
  - R: a=rs1, b=rs2. I/IL/S/JI: a=rs1, b=imm. U: a=zero, b=imm. UP/J/B: a=old_pc, b=imm.
  - B: taken = funct3 0:eq, 1:!eq, 4:lt, 5:!lt, 6:ltu, 7:!ltu. pc_write=taken, pc_src=1. Then FETCH; instret++.
  - J/JI: pc_write=1, pc_src=1 (datapath clears bit0 for JI). Then WB.
  - IL/S → MEM. R/I/U/UP → WB.
- MEM:
  - mem_req=1, adr_src=1, mem_we=(fmt==S).
  - Hold until mem_ready.
  - S: then FETCH; instret++. IL: then WB.
- WB (1 cycle):
  - reg_write=1.
  - result_src: IL→1, J/JI→2, else 0.
  - Then FETCH; instret++.
- HALT: halt=1. TRAP: illegal=1. Both are absorbing until reset; no memory requests in either.
- Latency at zero wait states:
  - branch 3 cycles; R/I/U/UP/S/J/JI 4 cycles; load 5 cycles.
  - Each wait cycle on mem_ready adds 1.
- mem_ready outside FETCH/MEM: ignored.
- instret wraps modulo 2^CNT_W.
- funct3/funct7 are continuous slices of instr; the decoder gates them via fmt.

Decomposition:
- Shared package riscv_pkg holds:
  - fmt codes (0–9) and opcode constants;
  - state encoding FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP;
  - mux-select encodings for alu_src_a, alu_src_b, result_src, pc_src, adr_src.
- Sub-module fmt_dec: combinational opcode→{fmt, legal} mapping, reused by the ALU-decoder testbench.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready held 1 → fmt=0 from cycle 2. reg_write=1 only in cycle 4 with result_src=0. instret 0→1.
- lw x5,8(x1) (0x0080A283), mem_ready low 2 cycles in MEM → mem_req=1, adr_src=1, mem_we=0 for 3 cycles. WB result_src=1. Total 7 cycles.
- beq x1,x2,+16 with br_eq=1 → EXEC: pc_write=1, pc_src=1, alu_src_a=1, alu_src_b=1. Next cycle FETCH. With br_eq=0: pc_write=0 in EXEC.
- sw in progress, rst pulsed mid-MEM → mem_req and mem_we drop the same cycle. State FETCH; instret=0.
- ecall (0x00000073) → halt=1 from cycle 3 and stays. No further mem_req over 20 cycles.
- opcode 0x7F, then B with funct3=2 → illegal=1 sticky, reg_write never asserted.
